// File: rtl/bram_sdp_fifo_ctl_pkg.sv
// Shared helpers for the SDP-BRAM FIFO controller: parameter checks, counter width, pointer wrap.
// No logic of its own; latency and backpressure belong to the modules that import it.
package bram_sdp_fifo_ctl_pkg;

    function automatic bit del_legal(input int del);
        return (del == 1) || (del == 2);
    endfunction

    function automatic int cnt_width(input int adr);
        return adr + 1;
    endfunction

    // Pointer increment over a ring of dep entries; dep need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned dep);
        return (ptr >= dep - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/bram_sdp_fifo_obuf.sv
// In-order register FIFO that absorbs RAM read data; head visible combinationally, 1-cycle write-to-head.
// Never refuses a push: the controller only issues reads that are guaranteed a slot here.
module bram_sdp_fifo_obuf
    import bram_sdp_fifo_ctl_pkg::*;
#(
    parameter int DAT   = 18,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DAT-1:0]             push_dat,
    input  logic                       pop,
    output logic [DAT-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0] ocnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DAT-1:0] mem_q [DEPTH];
    logic [DAT-1:0] mem_d [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [OW-1:0]  ocnt_q, ocnt_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        ocnt_d = ocnt_q + OW'(push) - OW'(pop);
        if (push) begin
            mem_d[tail_q] = push_dat;
            tail_d        = PW'(wrap_inc(32'(tail_q), 32'(DEPTH)));
        end
        if (pop) begin
            head_d = PW'(wrap_inc(32'(head_q), 32'(DEPTH)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q  <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            ocnt_q <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            ocnt_q <= ocnt_d;
        end
    end

    assign head_dat = mem_q[head_q];
    assign ocnt     = ocnt_q;

endmodule

// File: rtl/bram_sdp_fifo_ctl.sv
// FIFO controller around an external simple-dual-port BRAM; push-to-rd_vld latency is 2+DEL cycles.
// wr_rdy drops at cnt==DEP (a same-cycle pop does not help); reads stall while the output buffer could overfill.
module bram_sdp_fifo_ctl
    import bram_sdp_fifo_ctl_pkg::*;
#(
    parameter int ADR = 10,
    parameter int DAT = 18,
    parameter int DEP = 1024,
    parameter int DEL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_vld,
    input  logic [DAT-1:0]            wr_dat,
    output logic                      wr_rdy,
    output logic                      rd_vld,
    output logic [DAT-1:0]            rd_dat,
    input  logic                      rd_rdy,
    output logic                      mem_wen,
    output logic [ADR-1:0]            mem_wad,
    output logic [DAT-1:0]            mem_wda,
    output logic                      mem_ren,
    output logic [ADR-1:0]            mem_rad,
    input  logic [DAT-1:0]            mem_rda,
    output logic [cnt_width(ADR)-1:0] cnt,
    output logic                      err_ovf
);
    localparam int CW = cnt_width(ADR);
    localparam int OW = $clog2(DEL + 2);
    localparam logic [CW-1:0] DEP_C = CW'(DEP);

    if (!del_legal(DEL) || DEP < 2 || DEP > 2 ** ADR) begin : g_bad_param
        $error("bram_sdp_fifo_ctl: DEL must be 1 or 2 and 2 <= DEP <= 2**ADR");
    end

    logic [ADR-1:0] wptr_q, wptr_d;
    logic [ADR-1:0] rptr_q, rptr_d;
    logic [CW-1:0]  scnt_q, scnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DEL-1:0] infl_q, infl_d;
    logic           err_ovf_q, err_ovf_d;
    logic           push, pop, issue, cap;
    logic [OW-1:0]  infl, ocnt;

    assign wr_rdy = rst & (cnt_q < DEP_C);
    assign rd_vld = rst & (ocnt != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & rd_rdy;
    assign infl   = OW'($countones(infl_q));
    // Reserve an output-buffer slot for every read in flight so captured data always fits.
    assign issue  = rst && (scnt_q != '0) && (int'(infl) + int'(ocnt) < DEL + 1 + int'(pop));
    assign cap    = rst & infl_q[DEL-1];

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        scnt_d    = scnt_q + CW'(push) - CW'(issue);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        infl_d    = DEL'({infl_q, issue});
        err_ovf_d = err_ovf_q | (wr_vld & ~wr_rdy);
        if (push) begin
            wptr_d = ADR'(wrap_inc(32'(wptr_q), 32'(DEP)));
        end
        if (issue) begin
            rptr_d = ADR'(wrap_inc(32'(rptr_q), 32'(DEP)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            scnt_q    <= '0;
            cnt_q     <= '0;
            infl_q    <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            scnt_q    <= scnt_d;
            cnt_q     <= cnt_d;
            infl_q    <= infl_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    bram_sdp_fifo_obuf #(
        .DAT   (DAT),
        .DEPTH (DEL + 1)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .push     (cap),
        .push_dat (mem_rda),
        .pop      (pop),
        .head_dat (rd_dat),
        .ocnt     (ocnt)
    );

    assign mem_wen = push;
    assign mem_wad = wptr_q;
    assign mem_wda = wr_dat;
    assign mem_ren = issue;
    assign mem_rad = rptr_q;
    assign cnt     = cnt_q;
    assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_bram_sdp_fifo_ctl.sv
// Bench for bram_sdp_fifo_ctl: DEL=1 and DEL=2 instances, both DEP=5, each with its own SDP RAM model.
module tb_bram_sdp_fifo_ctl;
    localparam int ADR = 3;
    localparam int DAT = 18;
    localparam int DEP = 5;

    logic           clk;
    logic           rst;
    logic           wr_vld;
    logic [DAT-1:0] wr_dat;
    logic           rd_rdy;

    logic           wr_rdy_a, rd_vld_a, mem_wen_a, mem_ren_a, err_a;
    logic [DAT-1:0] rd_dat_a, mem_wda_a, mem_rda_a;
    logic [ADR-1:0] mem_wad_a, mem_rad_a;
    logic [ADR:0]   cnt_a;

    logic           wr_rdy_b, rd_vld_b, mem_wen_b, mem_ren_b, err_b;
    logic [DAT-1:0] rd_dat_b, mem_wda_b, mem_rda_b, rda_b1;
    logic [ADR-1:0] mem_wad_b, mem_rad_b;
    logic [ADR:0]   cnt_b;

    logic [DAT-1:0] ram_a [8];
    logic [DAT-1:0] ram_b [8];

    int checks = 0;
    int errors = 0;

    bram_sdp_fifo_ctl #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .DEL(1)) u_a (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_rdy(wr_rdy_a),
        .rd_vld(rd_vld_a), .rd_dat(rd_dat_a), .rd_rdy(rd_rdy),
        .mem_wen(mem_wen_a), .mem_wad(mem_wad_a), .mem_wda(mem_wda_a),
        .mem_ren(mem_ren_a), .mem_rad(mem_rad_a), .mem_rda(mem_rda_a),
        .cnt(cnt_a), .err_ovf(err_a)
    );

    bram_sdp_fifo_ctl #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .DEL(2)) u_b (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_rdy(wr_rdy_b),
        .rd_vld(rd_vld_b), .rd_dat(rd_dat_b), .rd_rdy(rd_rdy),
        .mem_wen(mem_wen_b), .mem_wad(mem_wad_b), .mem_wda(mem_wda_b),
        .mem_ren(mem_ren_b), .mem_rad(mem_rad_b), .mem_rda(mem_rda_b),
        .cnt(cnt_b), .err_ovf(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SDP RAM models: one-cycle and two-cycle read latency.
    always @(posedge clk) begin
        if (mem_wen_a) ram_a[mem_wad_a] <= mem_wda_a;
        if (mem_ren_a) mem_rda_a <= ram_a[mem_rad_a];
        if (mem_wen_b) ram_b[mem_wad_b] <= mem_wda_b;
        if (mem_ren_b) rda_b1 <= ram_b[mem_rad_b];
        mem_rda_b <= rda_b1;
    end

    typedef struct {
        logic           rst;
        logic           wv;
        logic [DAT-1:0] wd;
        logic           rr;
        logic           e_wrdy;
        logic           e_rvld;
        logic           chk_dat;
        logic [DAT-1:0] e_dat;
        logic           e_wen;
        logic           e_ren;
        logic [ADR:0]   e_cnt;
        logic           e_err;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b0; wr_vld = 1'b0; wr_dat = '0; rd_rdy = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcv, nwr, nrd, last_pop, bubbles, cnt_bad, inv_bad, stale;
        logic [DAT-1:0] q [$];
        logic [DAT-1:0] exp_d;

        //          rst wv  wd        rr  wrdy rvld cd  dat       wen ren cnt err
        tbl[0]  = '{0, 0, 18'h000, 0, 0, 0, 0, 18'h000, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 18'h0A5, 1, 1, 0, 0, 18'h000, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 18'h000, 1, 1, 0, 0, 18'h000, 0, 1, 1, 0};
        tbl[3]  = '{1, 0, 18'h000, 1, 1, 0, 0, 18'h000, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 18'h000, 1, 1, 1, 1, 18'h0A5, 0, 0, 1, 0};
        tbl[5]  = '{1, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 18'h001, 0, 1, 0, 0, 18'h000, 1, 0, 0, 0};
        tbl[7]  = '{1, 1, 18'h002, 0, 1, 0, 0, 18'h000, 1, 1, 1, 0};
        tbl[8]  = '{1, 1, 18'h003, 0, 1, 0, 0, 18'h000, 1, 1, 2, 0};
        tbl[9]  = '{1, 1, 18'h004, 0, 1, 1, 1, 18'h001, 1, 0, 3, 0};
        tbl[10] = '{1, 1, 18'h005, 0, 1, 1, 1, 18'h001, 1, 0, 4, 0};
        tbl[11] = '{1, 1, 18'h006, 0, 0, 1, 1, 18'h001, 0, 0, 5, 0};
        tbl[12] = '{1, 0, 18'h000, 0, 0, 1, 1, 18'h001, 0, 0, 5, 1};
        tbl[13] = '{1, 1, 18'h007, 1, 0, 1, 1, 18'h001, 0, 1, 5, 1};
        tbl[14] = '{1, 0, 18'h000, 0, 1, 1, 1, 18'h002, 0, 0, 4, 1};
        tbl[15] = '{0, 0, 18'h000, 0, 0, 0, 0, 18'h000, 0, 0, 4, 1};
        tbl[16] = '{1, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0, 0};
        tbl[17] = '{1, 0, 18'h000, 1, 1, 0, 0, 18'h000, 0, 0, 0, 0};

        rst = 1'b0; wr_vld = 1'b0; wr_dat = '0; rd_rdy = 1'b0;
        do_reset();
        rst = 1'b0;

        // Latency, fill to full, overflow, pop at full, reset of the DEL=1 instance.
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            rst = tbl[i].rst; wr_vld = tbl[i].wv; wr_dat = tbl[i].wd; rd_rdy = tbl[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d_wr_rdy", i), 32'(wr_rdy_a), 32'(tbl[i].e_wrdy));
            chk($sformatf("v%0d_rd_vld", i), 32'(rd_vld_a), 32'(tbl[i].e_rvld));
            if (tbl[i].chk_dat) chk($sformatf("v%0d_rd_dat", i), 32'(rd_dat_a), 32'(tbl[i].e_dat));
            chk($sformatf("v%0d_mem_wen", i), 32'(mem_wen_a), 32'(tbl[i].e_wen));
            chk($sformatf("v%0d_mem_ren", i), 32'(mem_ren_a), 32'(tbl[i].e_ren));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_err_ovf", i), 32'(err_a), 32'(tbl[i].e_err));
        end

        // Stream 12 words through DEL=1: order, address wrap, no bubbles.
        do_reset();
        sent = 0; rcv = 0; nwr = 0; nrd = 0; last_pop = -1; bubbles = 0;
        for (int cyc = 0; cyc < 80 && rcv < 12; cyc++) begin
            next_cycle();
            wr_vld = (sent < 12); wr_dat = DAT'(sent + 1); rd_rdy = 1'b1;
            @(negedge clk);
            if (mem_wen_a) begin
                chk($sformatf("stream_wad%0d", nwr), 32'(mem_wad_a), 32'(nwr % DEP));
                nwr++;
            end
            if (mem_ren_a) begin
                chk($sformatf("stream_rad%0d", nrd), 32'(mem_rad_a), 32'(nrd % DEP));
                nrd++;
            end
            if (wr_vld && wr_rdy_a) sent++;
            if (rd_vld_a) begin
                chk($sformatf("stream_dat%0d", rcv), 32'(rd_dat_a), 32'(rcv + 1));
                if (last_pop >= 0 && cyc != last_pop + 1) bubbles++;
                last_pop = cyc;
                rcv++;
            end
        end
        wr_vld = 1'b0;
        chk("stream_count", 32'(rcv), 32'd12);
        chk("stream_bubbles", 32'(bubbles), 32'd0);

        // DEL=2 with random push/pop pressure against a queue model.
        do_reset();
        sent = 0; rcv = 0; cnt_bad = 0; inv_bad = 0;
        q.delete();
        for (int cyc = 0; cyc < 4000 && rcv < 200; cyc++) begin
            next_cycle();
            wr_vld = (sent < 200) && ($urandom_range(0, 3) != 0);
            wr_dat = DAT'(sent + 1);
            rd_rdy = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (32'(cnt_b) != q.size()) cnt_bad++;
            if (u_b.ocnt > 3 || 32'(u_b.infl) + 32'(u_b.ocnt) > 3) inv_bad++;
            if (wr_vld && wr_rdy_b) begin
                q.push_back(wr_dat);
                sent++;
            end
            if (rd_vld_b && rd_rdy) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                chk($sformatf("rand_dat%0d", rcv), 32'(rd_dat_b), 32'(exp_d));
                rcv++;
            end
        end
        wr_vld = 1'b0;
        chk("rand_count", 32'(rcv), 32'd200);
        chk("rand_cnt_model", 32'(cnt_bad), 32'd0);
        chk("rand_occupancy", 32'(inv_bad), 32'd0);

        // Three words in flight on DEL=2, then a one-cycle reset.
        next_cycle();
        rd_rdy = 1'b0; wr_vld = 1'b1; wr_dat = 18'h00111;
        next_cycle();
        wr_dat = 18'h00222;
        next_cycle();
        wr_dat = 18'h00333;
        next_cycle();
        wr_vld = 1'b0; rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cnt", 32'(cnt_b), 32'd0);
        chk("rst_rd_vld", 32'(rd_vld_b), 32'd0);
        chk("rst_err_ovf", 32'(err_b), 32'd0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            rd_rdy = 1'b1;
            @(negedge clk);
            if (rd_vld_b) stale++;
        end
        chk("rst_stale", 32'(stale), 32'd0);

        next_cycle();
        wr_vld = 1'b1; wr_dat = 18'h00444;
        next_cycle();
        wr_vld = 1'b0;
        rcv = 0;
        for (int i = 0; i < 10 && rcv == 0; i++) begin
            @(negedge clk);
            if (rd_vld_b) begin
                chk("post_rst_dat", 32'(rd_dat_b), 32'h444);
                rcv++;
            end
            next_cycle();
        end
        chk("post_rst_count", 32'(rcv), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
